// File: rtl/gpi_irq_ctrl.sv
// GPI interrupt controller: per-bit synchronizer and debounce, configurable edge
// detection, W1C pending bits and a masked level interrupt on the peripheral bus.
module gpi_irq_ctrl #(
   parameter int WIDTH = 8,
   parameter int DEBOUNCE_CYCLES = 16,
   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cs,
   input  logic             wr,
   input  logic [1:0]       addr,
   input  logic [31:0]      wdata,
   output logic [31:0]      rdata,
   input  logic [WIDTH-1:0] gpi,
   output logic             irq
);

   logic [WIDTH-1:0] sync1;
   logic [WIDTH-1:0] s;
   logic [WIDTH-1:0] stable;
   logic [CNT_W-1:0] cnt [WIDTH];
   logic [WIDTH-1:0] settle;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;
   logic [WIDTH-1:0] pend;
   logic [WIDTH-1:0] pend_clr;
   logic [WIDTH-1:0] mask;
   logic             wr_cfg;
   logic             wr_pend;
   logic             wr_mask;
   logic             unused_wdata;

   assign wr_cfg  = cs & wr & (addr == 2'd1);
   assign wr_pend = cs & wr & (addr == 2'd2);
   assign wr_mask = cs & wr & (addr == 2'd3);

   // Bits of wdata above WIDTH in each field are intentionally ignored.
   assign unused_wdata = ^wdata;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         s     <= '0;
      end else begin
         sync1 <= gpi;
         s     <= sync1;
      end
   end

   // A bit settles on the cycle its mismatch count has already reached the limit.
   always_comb begin
      settle = '0;
      for (int i = 0; i < WIDTH; i++) begin
         settle[i] = (s[i] != stable[i]) && (cnt[i] >= CNT_W'(DEBOUNCE_CYCLES - 1));
      end
   end

   assign rise = settle & s & rise_en;
   assign fall = settle & ~s & fall_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stable <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            cnt[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (s[i] == stable[i]) begin
               cnt[i] <= '0;
            end else if (!settle[i]) begin
               cnt[i] <= cnt[i] + CNT_W'(1);
            end else begin
               stable[i] <= s[i];
               cnt[i]    <= '0;
            end
         end
      end
   end

   assign pend_clr = wr_pend ? wdata[WIDTH-1:0] : '0;

   // New events are OR'ed in after the clear so a simultaneous set wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rise_en <= '0;
         fall_en <= '0;
         mask    <= '0;
         pend    <= '0;
      end else begin
         if (wr_cfg) begin
            rise_en <= wdata[WIDTH-1:0];
            fall_en <= wdata[16+WIDTH-1:16];
         end
         if (wr_mask) begin
            mask <= wdata[WIDTH-1:0];
         end
         pend <= (pend & ~pend_clr) | rise | fall;
      end
   end

   always_comb begin
      rdata = '0;
      if (cs && !wr) begin
         case (addr)
            2'd0: rdata[WIDTH-1:0] = stable;
            2'd1: begin
               rdata[WIDTH-1:0]     = rise_en;
               rdata[16+WIDTH-1:16] = fall_en;
            end
            2'd2: rdata[WIDTH-1:0] = pend;
            2'd3: rdata[WIDTH-1:0] = mask;
            default: rdata = '0;
         endcase
      end
   end

   assign irq = |(pend & mask);

endmodule

// File: tb/tb_gpi_irq_ctrl.sv
// Self-checking bench for gpi_irq_ctrl: directed scenarios plus randomized traffic
// compared against a sliding-window behavioural model of debounce and edge latching.
module tb_gpi_irq_ctrl;

   localparam int DEB = 4;

   logic        clk;
   logic        reset;
   logic        cs;
   logic        wr;
   logic [1:0]  addr;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic [7:0]  gpi;
   logic        irq;

   int checks = 0;
   int errors = 0;

   logic [31:0] rdData, rdCfg, rdPend, rdMask;

   logic [7:0] mStable, mRiseEn, mFallEn, mPend, mMask;
   logic [7:0] mSamp[$];
   logic [7:0] mSHist[$];

   gpi_irq_ctrl #(.WIDTH(8), .DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk),
      .reset(reset),
      .cs(cs),
      .wr(wr),
      .addr(addr),
      .wdata(wdata),
      .rdata(rdata),
      .gpi(gpi),
      .irq(irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: a level is accepted once the last DEB synchronized samples all disagree with it.
   task automatic modelReset();
      mStable = '0;
      mRiseEn = '0;
      mFallEn = '0;
      mPend   = '0;
      mMask   = '0;
      mSamp   = '{8'h00, 8'h00};
      mSHist.delete();
   endtask

   task automatic modelStep();
      logic [7:0] sNow, ev, nxt, clr;
      bit allDiff;
      sNow = mSamp[0];
      void'(mSamp.pop_front());
      mSamp.push_back(gpi);
      mSHist.push_back(sNow);
      if (mSHist.size() > DEB) void'(mSHist.pop_front());
      ev  = '0;
      nxt = mStable;
      for (int b = 0; b < 8; b++) begin
         if (mSHist.size() == DEB) begin
            allDiff = 1'b1;
            foreach (mSHist[j]) if (mSHist[j][b] == mStable[b]) allDiff = 1'b0;
            if (allDiff) begin
               nxt[b] = ~mStable[b];
               ev[b]  = nxt[b] ? mRiseEn[b] : mFallEn[b];
            end
         end
      end
      clr   = (cs && wr && addr == 2'd2) ? wdata[7:0] : 8'h00;
      mPend = (mPend & ~clr) | ev;
      if (cs && wr && addr == 2'd1) begin
         mRiseEn = wdata[7:0];
         mFallEn = wdata[23:16];
      end
      if (cs && wr && addr == 2'd3) mMask = wdata[7:0];
      mStable = nxt;
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         if (reset) modelReset();
         else modelStep();
      end
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] v);
      @(negedge clk);
      gpi = v;
   endtask

   task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      cs = 1'b1;
      wr = 1'b1;
      addr = a;
      wdata = d;
      @(negedge clk);
      cs = 1'b0;
      wr = 1'b0;
   endtask

   task automatic busRead(input logic [1:0] a, output logic [31:0] d);
      cs = 1'b1;
      wr = 1'b0;
      addr = a;
      #1;
      d = rdata;
      cs = 1'b0;
   endtask

   task automatic checkModel(input string tag);
      busRead(2'd0, rdData);
      busRead(2'd1, rdCfg);
      busRead(2'd2, rdPend);
      busRead(2'd3, rdMask);
      checkOutput({tag, "/DATA"}, rdData, {24'h0, mStable});
      checkOutput({tag, "/EDGE_CFG"}, rdCfg, {8'h0, mFallEn, 8'h0, mRiseEn});
      checkOutput({tag, "/PEND"}, rdPend, {24'h0, mPend});
      checkOutput({tag, "/MASK"}, rdMask, {24'h0, mMask});
      checkOutput({tag, "/irq"}, {31'h0, irq}, {31'h0, |(mPend & mMask)});
   endtask

   initial begin
      int sel;
      gpi = '0;
      cs = 1'b0;
      wr = 1'b0;
      addr = '0;
      wdata = '0;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;

      @(negedge clk);
      checkModel("reset");
      checkOutput("reset_data", rdData, 32'h0);
      checkOutput("reset_cfg", rdCfg, 32'h0);
      checkOutput("reset_pend", rdPend, 32'h0);
      checkOutput("reset_mask", rdMask, 32'h0);
      checkOutput("reset_irq", {31'h0, irq}, 32'h0);
      addr = 2'd1;
      #1;
      checkOutput("idle_rdata", rdata, 32'h0);

      busWrite(2'd1, 32'h0000_0001);
      busWrite(2'd3, 32'h0000_0001);
      applyStimulus(8'h01);
      repeat (5) @(negedge clk);
      checkModel("deb_k4");
      checkOutput("deb_k4_data", rdData, 32'h0);
      checkOutput("deb_k4_irq", {31'h0, irq}, 32'h0);
      @(negedge clk);
      checkModel("deb_k5");
      checkOutput("deb_k5_data", rdData, 32'h1);
      checkOutput("deb_k5_pend", rdPend, 32'h1);
      checkOutput("deb_k5_irq", {31'h0, irq}, 32'h1);

      busWrite(2'd2, 32'h0000_0001);
      checkOutput("clr_irq", {31'h0, irq}, 32'h0);
      busWrite(2'd1, 32'h0008_0009);
      applyStimulus(8'h09);
      repeat (2) @(negedge clk);
      applyStimulus(8'h01);
      repeat (8) @(negedge clk);
      checkModel("glitch");
      checkOutput("glitch_data", rdData, 32'h1);
      checkOutput("glitch_pend", rdPend, 32'h0);
      checkOutput("glitch_irq", {31'h0, irq}, 32'h0);

      busWrite(2'd1, 32'h0001_0001);
      applyStimulus(8'h00);
      repeat (6) @(negedge clk);
      checkModel("fall0");
      checkOutput("fall0_pend", rdPend, 32'h1);
      applyStimulus(8'h01);
      repeat (6) @(negedge clk);
      applyStimulus(8'h00);
      repeat (4) @(negedge clk);
      busWrite(2'd2, 32'h0000_0001);
      checkModel("collide");
      checkOutput("collide_pend", rdPend, 32'h1);
      checkOutput("collide_irq", {31'h0, irq}, 32'h1);
      busWrite(2'd2, 32'h0000_0001);
      checkModel("clear");
      checkOutput("clear_pend", rdPend, 32'h0);
      checkOutput("clear_irq", {31'h0, irq}, 32'h0);

      busWrite(2'd1, 32'h0080_0000);
      busWrite(2'd3, 32'h0000_0000);
      applyStimulus(8'h80);
      repeat (7) @(negedge clk);
      checkModel("b7_high");
      checkOutput("b7_high_pend", rdPend, 32'h0);
      applyStimulus(8'h00);
      repeat (7) @(negedge clk);
      checkModel("b7_low");
      checkOutput("b7_low_pend", rdPend, 32'h80);
      checkOutput("b7_low_irq", {31'h0, irq}, 32'h0);
      busWrite(2'd3, 32'h0000_0080);
      checkOutput("mask_irq", {31'h0, irq}, 32'h1);

      applyStimulus(8'hFF);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      checkModel("midreset");
      checkOutput("midreset_cfg", rdCfg, 32'h0);
      checkOutput("midreset_pend", rdPend, 32'h0);
      checkOutput("midreset_mask", rdMask, 32'h0);
      checkOutput("midreset_irq", {31'h0, irq}, 32'h0);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      busWrite(2'd1, 32'h0000_00FF);
      repeat (3) @(negedge clk);
      checkModel("held_r5");
      checkOutput("held_r5_pend", rdPend, 32'h0);
      @(negedge clk);
      checkModel("held_r6");
      checkOutput("held_r6_pend", rdPend, 32'hFF);
      checkOutput("held_r6_data", rdData, 32'hFF);

      for (int it = 0; it < 250; it++) begin
         sel = int'($urandom_range(0, 9));
         if (sel < 5) begin
            applyStimulus(gpi ^ 8'(1 << $urandom_range(0, 7)) ^ (($urandom_range(0, 3) == 0) ? 8'($urandom()) : 8'h00));
            repeat ($urandom_range(0, 7)) @(negedge clk);
         end else if (sel < 9) begin
            busWrite(2'($urandom_range(0, 3)), $urandom());
         end else begin
            @(negedge clk);
            reset = 1'b1;
            @(negedge clk);
            reset = 1'b0;
         end
         checkModel("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/gpi_irq_ctrl.md
Name: gpi_irq_ctrl

Overview:
Register-mapped controller for the 8-bit general-purpose input port on the CPU peripheral bus. It synchronizes and debounces each input bit, then detects rising and falling edges per bit under software configuration. It latches edge events into write-1-to-clear pending bits and drives a masked interrupt line to the CPU. It replaces direct polling of raw input pins.

Parameters:
- WIDTH, 8: number of input bits; legal range 1..16.
- DEBOUNCE_CYCLES, 16: consecutive synchronized-mismatch cycles required to accept a new level; minimum 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): per-bit debounce counter width; derived, do not override.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: reset.
- cs, input, 1: peripheral select.
- wr, input, 1: 1 = write, 0 = read; valid with cs.
- addr, input, 2: register word index.
- wdata, input, 32: write data.
- rdata, output, 32: read data.
- gpi, input, WIDTH: raw asynchronous input pins.
- irq, output, 1: level interrupt to the CPU.

Behaviour:
- Clock and reset: reset is asynchronous, active-high; clock is clk. All flops reset to 0. This covers the synchronizers, debounce counters, stable level, EDGE_CFG, PEND and MASK.
- Register map (addr):
  - 0 DATA: RO, debounced stable level in bits [WIDTH-1:0].
  - 1 EDGE_CFG: RW. Bits [WIDTH-1:0] are rise enable; bits [16+WIDTH-1:16] are fall enable.
  - 2 PEND: RW1C. Pending edge events.
  - 3 MASK: RW. Interrupt enable per bit.
  - Unimplemented bits read 0; writes to them are ignored. Writes to DATA are ignored.
- Bus timing:
  - A write takes effect at the clk edge where cs=1 and wr=1.
  - A read is combinational: rdata = selected register when cs=1 and wr=0, else 32'h0. No wait states.
- Synchronizer: two-flop chain per bit, s = second stage. gpi changes are visible on s two edges later.
- Debounce (per bit i):
  - If s[i]==stable[i]: cnt[i] <= 0.
  - Else if cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - Else: stable[i] <= s[i] and cnt[i] <= 0.
  - Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles restarts the count and never changes stable.
  - Latency: a change sampled at edge k updates stable at edge k+1+DEBOUNCE_CYCLES.
- Edge detect, evaluated on the same edge that updates stable:
  - rise[i] = new stable[i] & ~old stable[i] & rise_en[i].
  - fall[i] = ~new stable[i] & old stable[i] & fall_en[i].
  - PEND[i] <= 1 when rise[i] or fall[i].
- PEND clear:
  - Writing 1 to bit i clears it; writing 0 has no effect.
  - A set and a clear in the same cycle: set wins, so the bit stays 1.
  - Changing EDGE_CFG does not clear existing PEND bits.
- irq = |(PEND & MASK), combinational from flops only, so glitch-free.
  - irq rises in the cycle after the edge that sets PEND, if the bit is masked-in.
  - Setting MASK over an already-pending bit asserts irq the cycle after the write.
  - irq deasserts the cycle after the last contributing bit is cleared or masked.
- Reset behaviour:
  - Reset mid-debounce discards the count.
  - An input held high across reset produces a rise event DEBOUNCE_CYCLES+2 cycles after reset release. The event is latched only if rise_en has been set by then.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then read all four registers -> each reads 0; irq=0.
2. Write EDGE_CFG=0x0000_0001, MASK=0x01. Drive gpi[0] 0->1 before edge k and hold -> DATA reads 0x01 after edge k+5; PEND reads 0x01; irq=1 from cycle k+6.
3. Pulse gpi[3] high for 3 cycles with both edge enables on for bit 3 -> DATA bit 3 stays 0; PEND stays 0; irq stays 0.
4. Pending bit 0 set; write PEND=0x01 on the same edge a new enabled fall on bit 0 lands -> PEND bit 0 remains 1; irq stays 1. A subsequent write PEND=0x01 -> PEND=0, irq=0 next cycle.
5. Enable fall on bit 7 only (EDGE_CFG=0x0080_0000) and leave MASK=0. Toggle gpi[7] 0->1->0 with each level held for 8 cycles -> PEND=0x80 only after the falling edge, irq=0. Then write MASK=0x80 -> irq=1 the next cycle.
6. Drive gpi=0xFF through and after reset with EDGE_CFG written to 0x0000_00FF right after release -> PEND=0xFF at reset release + 6 cycles. Assert reset mid-count -> all registers return to 0 immediately.
